digseg_scan_ctrl: RTL and testbench

Wishbone-style slave that owns an 8-digit, time-multiplexed hex seven-segment display.
- Holds eight 4-bit digit values and a control register written over the system bus.
- A prescaled scan sequencer rotates through the digits, driving one active-low anode and the decoded segment pattern at a time.
- Sits on the peripheral bus beside the other memory-mapped I/O; replaces per-digit static drivers with one shared segment bus.

---
 rtl/digseg_scan_ctrl_if.sv | 20 ++
 rtl/digseg_scan_ctrl.sv | 159 +++++++++++++++
 tb/tb_digseg_scan_ctrl.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/digseg_scan_ctrl_if.sv
// Peripheral-bus bundle for the seven-segment scan controller.
// The CPU side uses the master modport; the display controller uses the slave modport.
interface digseg_scan_ctrl_if;
    logic [31:0] bus_addr_i;
    logic [31:0] bus_data_i;
    logic [31:0] bus_data_o;
    logic        bus_select_i;
    logic        bus_we_i;
    logic        bus_ack_o;

    modport master (
        output bus_addr_i, bus_data_i, bus_select_i, bus_we_i,
        input  bus_data_o, bus_ack_o
    );

    modport slave (
        input  bus_addr_i, bus_data_i, bus_select_i, bus_we_i,
        output bus_data_o, bus_ack_o
    );
endinterface

// File: rtl/digseg_scan_ctrl.sv
// Bus slave driving an 8-digit multiplexed hex seven-segment display (active-low).
// Optional per-digit blanking via CTRL[15:8] when DIGSEG_BLANK_EN is defined.
module digseg_scan_ctrl #(
    parameter logic [15:0] SCAN_DIV    = 16'd50000,
    parameter logic [31:0] RESET_VALUE = 32'h0000_0000
) (
    input  logic               clk,
    input  logic               rst,
    digseg_scan_ctrl_if.slave  bus,
    output logic [7:0]         an_o,
    output logic [6:0]         seg_o
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACK,
        ST_WAIT
    } bus_st_t;

    bus_st_t     r_state;
    logic        r_ack;
    logic [31:0] r_rdata;
    logic [31:0] r_data;
    logic        r_en;
    logic [15:0] r_pre;
    logic [2:0]  r_idx;
    logic [7:0]  r_an;
    logic [6:0]  r_seg;

    logic [31:0] w_ctrl;
    logic        w_blank;
    logic        w_dark;
    logic        w_wrap;
    logic [3:0]  w_digit;
    logic [6:0]  w_seg;
    logic        w_unused_addr;

    assign w_unused_addr = ^{bus.bus_addr_i[31:3], bus.bus_addr_i[1:0]};

`ifdef DIGSEG_BLANK_EN
    logic [7:0] r_blank;

    assign w_ctrl  = {16'h0, r_blank, 7'h0, r_en};
    assign w_blank = r_blank[r_idx];
`else
    assign w_ctrl  = {31'h0, r_en};
    assign w_blank = 1'b0;
`endif

    // Register update happens on the IDLE->ACK edge, so a reset during ACK
    // restores the reset contents and the transfer is effectively discarded.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_ack   <= 1'b0;
            r_rdata <= 32'h0;
            r_data  <= RESET_VALUE;
            r_en    <= 1'b1;
`ifdef DIGSEG_BLANK_EN
            r_blank <= 8'h00;
`endif
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_ack <= 1'b0;
                    if (bus.bus_select_i) begin
                        r_state <= ST_ACK;
                        r_ack   <= 1'b1;
                        if (bus.bus_we_i) begin
                            if (bus.bus_addr_i[2]) begin
                                r_en <= bus.bus_data_i[0];
`ifdef DIGSEG_BLANK_EN
                                r_blank <= bus.bus_data_i[15:8];
`endif
                            end else begin
                                r_data <= bus.bus_data_i;
                            end
                        end else begin
                            r_rdata <= bus.bus_addr_i[2] ? w_ctrl : r_data;
                        end
                    end
                end
                ST_ACK: begin
                    r_ack   <= 1'b0;
                    r_state <= ST_WAIT;
                end
                ST_WAIT: begin
                    r_ack <= 1'b0;
                    if (!bus.bus_select_i) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: begin
                    r_ack   <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.bus_ack_o  = r_ack;
    assign bus.bus_data_o = r_rdata;

    assign w_wrap  = (r_pre == SCAN_DIV - 16'd1);
    assign w_digit = r_data[{r_idx, 2'b00} +: 4];
    assign w_dark  = !r_en || w_blank;

    always_comb begin
        w_seg = 7'h7F;
        case (w_digit)
            4'h0: w_seg = 7'h40;
            4'h1: w_seg = 7'h79;
            4'h2: w_seg = 7'h24;
            4'h3: w_seg = 7'h30;
            4'h4: w_seg = 7'h19;
            4'h5: w_seg = 7'h12;
            4'h6: w_seg = 7'h02;
            4'h7: w_seg = 7'h78;
            4'h8: w_seg = 7'h00;
            4'h9: w_seg = 7'h10;
            4'hA: w_seg = 7'h08;
            4'hB: w_seg = 7'h03;
            4'hC: w_seg = 7'h46;
            4'hD: w_seg = 7'h21;
            4'hE: w_seg = 7'h06;
            4'hF: w_seg = 7'h0E;
            default: w_seg = 7'h7F;
        endcase
    end

    // Anode and segments come from the same register stage, so a digit never
    // lights with its neighbour's pattern.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pre <= 16'h0;
            r_idx <= 3'd0;
            r_an  <= 8'hFF;
            r_seg <= 7'h7F;
        end else begin
            if (w_wrap) begin
                r_pre <= 16'h0;
                r_idx <= r_idx + 3'd1;
            end else begin
                r_pre <= r_pre + 16'd1;
            end
            if (w_dark) begin
                r_an  <= 8'hFF;
                r_seg <= 7'h7F;
            end else begin
                r_an  <= ~(8'h01 << r_idx);
                r_seg <= w_seg;
            end
        end
    end

    assign an_o  = r_an;
    assign seg_o = r_seg;

endmodule

// File: tb/tb_digseg_scan_ctrl.sv
// Directed bench for digseg_scan_ctrl with SCAN_DIV=4; outputs sampled on negedge.
module tb_digseg_scan_ctrl;

    logic       clk;
    logic       rst;
    logic [7:0] an_o;
    logic [6:0] seg_o;
    int         passed;
    int         total;

    digseg_scan_ctrl_if u_if ();

    digseg_scan_ctrl #(
        .SCAN_DIV    (16'd4),
        .RESET_VALUE (32'h0000_0000)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .bus   (u_if.slave),
        .an_o  (an_o),
        .seg_o (seg_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Bus driver only: holds select for 'hold' cycles and reports what it saw.
    task automatic bus_xfer(input logic [31:0] addr, input logic [31:0] wdata, input logic we,
                            input int hold, output int n_ack, output int first_ack,
                            output logic [31:0] rdata);
        n_ack     = 0;
        first_ack = -1;
        rdata     = 32'h0;
        u_if.bus_addr_i   = addr;
        u_if.bus_data_i   = wdata;
        u_if.bus_we_i     = we;
        u_if.bus_select_i = 1'b1;
        for (int i = 1; i <= hold; i++) begin
            @(negedge clk);
            if (u_if.bus_ack_o === 1'b1) begin
                n_ack++;
                if (first_ack < 0) first_ack = i;
                rdata = u_if.bus_data_o;
            end
        end
        u_if.bus_select_i = 1'b0;
        u_if.bus_we_i     = 1'b0;
        @(negedge clk);
    endtask

    task automatic wait_an(input logic [7:0] target, input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget && !ok; i++) begin
            if (an_o === target) ok = 1'b1;
            else @(negedge clk);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        u_if.bus_select_i = 1'b0;
        u_if.bus_we_i     = 1'b0;
        u_if.bus_addr_i   = 32'h0;
        u_if.bus_data_i   = 32'h0;
        repeat (3) @(negedge clk);
        total++; if (an_o !== 8'hFF) $display("FAIL reset_an got %h exp FF", an_o); else passed++;
        total++; if (seg_o !== 7'h7F) $display("FAIL reset_seg got %h exp 7F", seg_o); else passed++;
        total++; if (u_if.bus_ack_o !== 1'b0) $display("FAIL reset_ack got %b exp 0", u_if.bus_ack_o); else passed++;
        total++; if (u_if.bus_data_o !== 32'h0) $display("FAIL reset_rdata got %h exp 0", u_if.bus_data_o); else passed++;
        rst = 1'b0;
        @(negedge clk);
        total++; if (an_o !== 8'hFE) $display("FAIL first_an got %h exp FE", an_o); else passed++;
        total++; if (seg_o !== 7'h40) $display("FAIL first_seg got %h exp 40", seg_o); else passed++;
    endtask

    task automatic test_scan();
        logic [7:0] exp_an;
        for (int k = 1; k <= 8; k++) begin
            repeat (4) @(negedge clk);
            exp_an = ~(8'h01 << (k % 8));
            total++; if (an_o !== exp_an) $display("FAIL scan_an step %0d got %h exp %h", k, an_o, exp_an); else passed++;
            total++; if (seg_o !== 7'h40) $display("FAIL scan_seg step %0d got %h exp 40", k, seg_o); else passed++;
        end
    endtask

    task automatic test_write_data();
        int          n_ack, first_ack;
        logic [31:0] rd;
        bit          ok;
        logic [6:0]  exp_a [8];
        logic [6:0]  exp_b [8];
        exp_a = '{7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00};
        exp_b = '{7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40};
        bus_xfer(32'h0, 32'h89AB_CDEF, 1'b1, 3, n_ack, first_ack, rd);
        total++; if (n_ack !== 1) $display("FAIL wr_ack_count got %0d exp 1", n_ack); else passed++;
        total++; if (first_ack !== 1) $display("FAIL wr_ack_latency got %0d exp 1", first_ack); else passed++;
        for (int i = 0; i < 8; i++) begin
            wait_an(~(8'h01 << i), 40, ok);
            total++;
            if (!ok || seg_o !== exp_a[i]) $display("FAIL dec_a digit %0d found %b seg %h exp %h", i, ok, seg_o, exp_a[i]);
            else passed++;
        end
        bus_xfer(32'h0, 32'h0123_4567, 1'b1, 2, n_ack, first_ack, rd);
        for (int i = 0; i < 8; i++) begin
            wait_an(~(8'h01 << i), 40, ok);
            total++;
            if (!ok || seg_o !== exp_b[i]) $display("FAIL dec_b digit %0d found %b seg %h exp %h", i, ok, seg_o, exp_b[i]);
            else passed++;
        end
        bus_xfer(32'h0, 32'h0, 1'b0, 2, n_ack, first_ack, rd);
        total++; if (rd !== 32'h0123_4567) $display("FAIL rd_data got %h exp 01234567", rd); else passed++;
    endtask

    task automatic test_read_ctrl();
        int          n_ack, first_ack;
        logic [31:0] rd;
        bus_xfer(32'h4, 32'h0, 1'b0, 10, n_ack, first_ack, rd);
        total++; if (n_ack !== 1) $display("FAIL held_sel_acks got %0d exp 1", n_ack); else passed++;
        total++; if (first_ack !== 1) $display("FAIL rd_ack_latency got %0d exp 1", first_ack); else passed++;
        total++; if (rd !== 32'h1) $display("FAIL rd_ctrl got %h exp 1", rd); else passed++;
        repeat (3) @(negedge clk);
        total++; if (u_if.bus_data_o !== 32'h1) $display("FAIL rdata_hold got %h exp 1", u_if.bus_data_o); else passed++;
    endtask

    task automatic test_enable();
        logic [7:0] prev;
        bit         found;
        found = 1'b0;
        prev  = an_o;
        for (int i = 0; i < 40 && !found; i++) begin
            @(negedge clk);
            if (an_o === 8'hFE && prev !== 8'hFE) found = 1'b1;
            prev = an_o;
        end
        total++; if (!found) $display("FAIL en_sync got timeout exp FE edge"); else passed++;
        u_if.bus_addr_i = 32'h4; u_if.bus_data_i = 32'h0; u_if.bus_we_i = 1'b1; u_if.bus_select_i = 1'b1;
        @(negedge clk);
        total++; if (u_if.bus_ack_o !== 1'b1) $display("FAIL en_wr_ack got %b exp 1", u_if.bus_ack_o); else passed++;
        @(negedge clk);
        total++; if (an_o !== 8'hFF || seg_o !== 7'h7F) $display("FAIL disable got %h/%h exp FF/7F", an_o, seg_o); else passed++;
        u_if.bus_select_i = 1'b0; u_if.bus_we_i = 1'b0;
        repeat (7) @(negedge clk);
        total++; if (an_o !== 8'hFF) $display("FAIL disabled_hold got %h exp FF", an_o); else passed++;
        u_if.bus_data_i = 32'h1; u_if.bus_we_i = 1'b1; u_if.bus_select_i = 1'b1;
        @(negedge clk);
        total++; if (an_o !== 8'hFF) $display("FAIL reen_latency got %h exp FF", an_o); else passed++;
        @(negedge clk);
        u_if.bus_select_i = 1'b0; u_if.bus_we_i = 1'b0;
        total++; if (an_o !== 8'hFB || seg_o !== 7'h12) $display("FAIL resume got %h/%h exp FB/12", an_o, seg_o); else passed++;
        @(negedge clk);
        total++; if (an_o !== 8'hF7) $display("FAIL resume_next got %h exp F7", an_o); else passed++;
    endtask

    task automatic test_reset_mid();
        int          n_ack, first_ack;
        logic [31:0] rd;
        u_if.bus_addr_i = 32'h0; u_if.bus_data_i = 32'h1234_5678; u_if.bus_we_i = 1'b1; u_if.bus_select_i = 1'b1;
        @(negedge clk);
        total++; if (u_if.bus_ack_o !== 1'b1) $display("FAIL mid_ack got %b exp 1", u_if.bus_ack_o); else passed++;
        rst = 1'b1;
        @(negedge clk);
        total++; if (u_if.bus_ack_o !== 1'b0) $display("FAIL mid_ack_drop got %b exp 0", u_if.bus_ack_o); else passed++;
        total++; if (an_o !== 8'hFF || seg_o !== 7'h7F) $display("FAIL mid_outputs got %h/%h exp FF/7F", an_o, seg_o); else passed++;
        rst = 1'b0; u_if.bus_select_i = 1'b0; u_if.bus_we_i = 1'b0;
        @(negedge clk);
        bus_xfer(32'h0, 32'h0, 1'b0, 2, n_ack, first_ack, rd);
        total++; if (rd !== 32'h0) $display("FAIL mid_data got %h exp 0", rd); else passed++;
        bus_xfer(32'h4, 32'h0, 1'b0, 2, n_ack, first_ack, rd);
        total++; if (rd !== 32'h1) $display("FAIL mid_ctrl got %h exp 1", rd); else passed++;
    endtask

    task automatic test_ctrl_mask();
        int          n_ack, first_ack;
        logic [31:0] rd;
        bus_xfer(32'h4, 32'h0000_0301, 1'b1, 2, n_ack, first_ack, rd);
        bus_xfer(32'h4, 32'h0, 1'b0, 2, n_ack, first_ack, rd);
`ifdef DIGSEG_BLANK_EN
        begin
            int bad;
            bit ok;
            total++; if (rd !== 32'h0000_0301) $display("FAIL blank_rd got %h exp 301", rd); else passed++;
            bad = 0;
            for (int i = 0; i < 40; i++) begin
                @(negedge clk);
                if (an_o === 8'hFE || an_o === 8'hFD) bad++;
            end
            total++; if (bad !== 0) $display("FAIL blank_slots got %0d lit cycles exp 0", bad); else passed++;
            wait_an(8'hFB, 40, ok);
            total++; if (!ok || seg_o !== 7'h40) $display("FAIL blank_digit2 found %b seg %h exp 40", ok, seg_o); else passed++;
        end
`else
        total++; if (rd !== 32'h1) $display("FAIL ctrl_mask_rd got %h exp 1", rd); else passed++;
`endif
    endtask

    initial begin
        passed = 0;
        total  = 0;
        test_reset();
        test_scan();
        test_write_data();
        test_read_ctrl();
        test_enable();
        test_reset_mid();
        test_ctrl_mask();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
